ps2_key_event_decoder: RTL and testbench

//  Turns the raw PS/2 set-2 byte stream from the keyboard receiver into key events.
//  It handles the E0 and F0 prefixes, suppresses typematic repeats and classifies keys.

---
 rtl/ps2_key_event_decoder.sv | 173 +++++++++++++++++
 tb/tb_ps2_key_event_decoder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder: PS/2 set-2 scancode bytes -> classified key events.
// Parses the E0/F0 prefixes, suppresses typematic repeats of the held key, and
// queues digit/Enter/Backspace events in a show-ahead FIFO read by valid/ready.
// Optional feature macro: PS2_NUMPAD_EN (keypad digits and keypad Enter).
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_err,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [3:0] evt_code,
  output logic       evt_full,
  output logic       key_held,
  output logic       ovf_sticky
);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} state_t;

  state_t             state, state_next;
  logic [7:0]         held_code;
  logic               held_ext;
  logic               push_req;
  logic [3:0]         push_code;
  logic               hold_set;
  logic               hold_ext_next;
  logic               hold_clr;
  logic [4:0]         cls;
  logic               pop;
  logic               do_push;
  logic               drop;
  logic [3:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;

  // Result is {hit, class}; hit=0 means the key is not one we report.
  function automatic logic [4:0] classify(input logic [7:0] code, input logic ext);
    logic [4:0] r;
    r = 5'd0;
    if (!ext) begin
      case (code)
        8'h45: r = {1'b1, 4'd0};
        8'h16: r = {1'b1, 4'd1};
        8'h1E: r = {1'b1, 4'd2};
        8'h26: r = {1'b1, 4'd3};
        8'h25: r = {1'b1, 4'd4};
        8'h2E: r = {1'b1, 4'd5};
        8'h36: r = {1'b1, 4'd6};
        8'h3D: r = {1'b1, 4'd7};
        8'h3E: r = {1'b1, 4'd8};
        8'h46: r = {1'b1, 4'd9};
        8'h5A: r = {1'b1, 4'd10};
        8'h66: r = {1'b1, 4'd11};
`ifdef PS2_NUMPAD_EN
        8'h70: r = {1'b1, 4'd0};
        8'h69: r = {1'b1, 4'd1};
        8'h72: r = {1'b1, 4'd2};
        8'h7A: r = {1'b1, 4'd3};
        8'h6B: r = {1'b1, 4'd4};
        8'h73: r = {1'b1, 4'd5};
        8'h74: r = {1'b1, 4'd6};
        8'h6C: r = {1'b1, 4'd7};
        8'h75: r = {1'b1, 4'd8};
        8'h7D: r = {1'b1, 4'd9};
`endif
        default: r = 5'd0;
      endcase
    end else begin
`ifdef PS2_NUMPAD_EN
      if (code == 8'h5A) r = {1'b1, 4'd10};
`else
      r = 5'd0;
`endif
    end
    return r;
  endfunction

  // Prefix state register; a reset mid-prefix restarts parsing from IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state plus make/break decisions for the byte being accepted.
  always_comb begin
    state_next    = state;
    push_req      = 1'b0;
    push_code     = 4'd0;
    hold_set      = 1'b0;
    hold_ext_next = 1'b0;
    hold_clr      = 1'b0;
    cls           = classify(rx_byte, state == EXT);
    if (rx_err) begin
      state_next = IDLE;
      hold_clr   = 1'b1;
    end else if (rx_valid) begin
      case (state)
        IDLE, EXT: begin
          if (state == IDLE && rx_byte == 8'hE0) begin
            state_next = EXT;
          end else if (rx_byte == 8'hF0) begin
            state_next = (state == IDLE) ? BRK : EXTBRK;
          end else begin
            state_next = IDLE;
            // Same key still down means the keyboard is auto-repeating.
            if (cls[4] && !(key_held && held_code == rx_byte && held_ext == (state == EXT))) begin
              push_req      = 1'b1;
              push_code     = cls[3:0];
              hold_set      = 1'b1;
              hold_ext_next = (state == EXT);
            end
          end
        end
        BRK, EXTBRK: begin
          state_next = IDLE;
          if (held_code == rx_byte && held_ext == (state == EXTBRK)) hold_clr = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Held-key tracking used for repeat suppression and key_held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_held  <= 1'b0;
      held_code <= 8'h00;
      held_ext  <= 1'b0;
    end else if (hold_clr) begin
      key_held  <= 1'b0;
    end else if (hold_set) begin
      key_held  <= 1'b1;
      held_code <= rx_byte;
      held_ext  <= hold_ext_next;
    end
  end

  assign pop     = evt_valid && evt_ready;
  assign do_push = push_req && (!evt_full || pop);
  assign drop    = push_req && evt_full && !pop;

  // FIFO pointers, occupancy and overflow flag; a full FIFO still accepts when popping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      count <= count + 1'b1;
      else if (pop && !do_push) count <= count - 1'b1;
      if (drop)         ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

  // Event storage; contents only matter behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_code;
  end

  assign evt_valid = (count != '0);
  assign evt_full  = (count == (FIFO_AW+1)'(FIFO_DEPTH));
  assign evt_code  = evt_valid ? mem[rd_ptr] : 4'd0;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder; expectations follow PS2_NUMPAD_EN.
module tb_ps2_key_event_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       evt_ready;
  logic       ovf_clr;
  logic       evt_valid;
  logic [3:0] evt_code;
  logic       evt_full;
  logic       key_held;
  logic       ovf_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  ps2_key_event_decoder #(.FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .evt_ready(evt_ready), .ovf_clr(ovf_clr), .evt_valid(evt_valid), .evt_code(evt_code),
    .evt_full(evt_full), .key_held(key_held), .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pop_one();
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [3:0] exp);
    check({tag, "_valid"}, 32'(evt_valid), 1);
    check({tag, "_code"}, 32'(evt_code), 32'(exp));
    pop_one();
  endtask

  initial begin
    rst = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_code", 32'(evt_code), 0);
    check("rst_full", 32'(evt_full), 0);
    check("rst_held", 32'(key_held), 0);
    check("rst_ovf", 32'(ovf_sticky), 0);
    rst = 1'b1;
    @(negedge clk);

    // T1: one event from make/break; latency one cycle
    check("t1_pre_valid", 32'(evt_valid), 0);
    send_byte(8'h3D);
    check("t1_lat_valid", 32'(evt_valid), 1);
    check("t1_held", 32'(key_held), 1);
    send_byte(8'hF0);
    send_byte(8'h3D);
    check("t1_released", 32'(key_held), 0);
    pop_check("t1_ev", 4'd7);
    check("t1_empty", 32'(evt_valid), 0);

    // Byte without rx_valid is ignored
    @(negedge clk); rx_byte = 8'h46;
    repeat (2) @(negedge clk);
    check("noval_empty", 32'(evt_valid), 0);

    // T2: typematic suppression
    send_byte(8'h16); send_byte(8'h16); send_byte(8'h16);
    send_byte(8'hF0); send_byte(8'h16); send_byte(8'h16);
    check("t2_held", 32'(key_held), 1);
    pop_check("t2_ev0", 4'd1);
    pop_check("t2_ev1", 4'd1);
    check("t2_empty", 32'(evt_valid), 0);
    send_byte(8'hF0); send_byte(8'h16);
    check("t2_released", 32'(key_held), 0);

    // T3: fill to depth, then drain in order
    send_byte(8'h45); send_byte(8'h2E); send_byte(8'h5A); send_byte(8'h66);
    check("t3_full", 32'(evt_full), 1);
    check("t3_ovf", 32'(ovf_sticky), 0);
    pop_check("t3_ev0", 4'd0);
    check("t3_notfull", 32'(evt_full), 0);
    pop_check("t3_ev1", 4'd5);
    pop_check("t3_ev2", 4'd10);
    pop_check("t3_ev3", 4'd11);
    check("t3_empty", 32'(evt_valid), 0);
    pop_one();
    check("t3_pop_empty", 32'(evt_valid), 0);
    send_byte(8'hF0); send_byte(8'h66);

    // T4: overflow, clear, push+pop while full
    send_byte(8'h16); send_byte(8'h1E); send_byte(8'h26); send_byte(8'h25); send_byte(8'h2E);
    check("t4_ovf", 32'(ovf_sticky), 1);
    check("t4_full", 32'(evt_full), 1);
    check("t4_head", 32'(evt_code), 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(ovf_sticky), 0);
    @(negedge clk); rx_byte = 8'h36; rx_valid = 1'b1; evt_ready = 1'b1;
    @(negedge clk); rx_valid = 1'b0; evt_ready = 1'b0;
    check("t4_nodrop_ovf", 32'(ovf_sticky), 0);
    check("t4_still_full", 32'(evt_full), 1);
    pop_check("t4_ev0", 4'd2);
    pop_check("t4_ev1", 4'd3);
    pop_check("t4_ev2", 4'd4);
    pop_check("t4_ev3", 4'd6);
    check("t4_empty", 32'(evt_valid), 0);
    send_byte(8'hF0); send_byte(8'h36);

    // T5: reset mid-prefix, then rx_err mid-prefix
    send_byte(8'hF0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    send_byte(8'h45);
    pop_check("t5_ev0", 4'd0);
    check("t5_held", 32'(key_held), 1);
    send_byte(8'hE0);
    @(negedge clk); rx_err = 1'b1;
    @(negedge clk); rx_err = 1'b0;
    check("t5_err_held", 32'(key_held), 0);
    send_byte(8'h3E);
    pop_check("t5_ev1", 4'd8);
    check("t5_empty", 32'(evt_valid), 0);
    @(negedge clk); rx_byte = 8'h16; rx_valid = 1'b1; rx_err = 1'b1;
    @(negedge clk); rx_valid = 1'b0; rx_err = 1'b0;
    check("t5_err_wins", 32'(evt_valid), 0);

    // T6: keypad Enter and keypad 1
    send_byte(8'hE0); send_byte(8'h5A); send_byte(8'h69);
`ifdef PS2_NUMPAD_EN
    pop_check("t6_ev0", 4'd10);
    pop_check("t6_ev1", 4'd1);
`endif
    check("t6_empty", 32'(evt_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
